// File: rtl/cci_mpf_prim_fifo_regn.sv
// Register-array FIFO with registered status flags and a per-age peek port.
// Storage is a circular buffer indexed by read/write pointers that wrap at
// N_ENTRIES, so the depth does not have to be a power of two.
module cci_mpf_prim_fifo_regn #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 4,
  parameter int THRESHOLD   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,

  input  logic [N_DATA_BITS-1:0]                 enq_data,
  input  logic                                   enq_en,
  output logic                                   notFull,
  output logic                                   almostFull,

  output logic [N_DATA_BITS-1:0]                 first,
  input  logic                                   deq_en,
  output logic                                   notEmpty,

  output logic [$clog2(N_ENTRIES+1)-1:0]         count,
  output logic [N_ENTRIES-1:0]                   peek_valid,
  output logic [N_ENTRIES-1:0][N_DATA_BITS-1:0]  peek_value
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam int CW = $clog2(N_ENTRIES+1);

  // Reject illegal geometries while elaborating.
  if (N_ENTRIES < 2) begin : g_bad_depth
    $fatal(1, "cci_mpf_prim_fifo_regn: N_ENTRIES must be at least 2");
  end
  if (THRESHOLD < 0 || THRESHOLD >= N_ENTRIES) begin : g_bad_threshold
    $fatal(1, "cci_mpf_prim_fifo_regn: THRESHOLD must be in 0..N_ENTRIES-1");
  end

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  int                     idx;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_ENTRIES-1)) ? '0 : p + PW'(1);
  endfunction

  // Control state: pointers and occupancy; reset wins over any strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_en) wr_ptr <= ptr_inc(wr_ptr);
      if (deq_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq_en, deq_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; never cleared, validity comes from count alone.
  always_ff @(posedge clk) begin
    if (enq_en) mem[wr_ptr] <= enq_data;
  end

  // Status flags depend only on the registered occupancy.
  assign notFull    = (count != CW'(N_ENTRIES));
  assign notEmpty   = (count != '0);
  assign almostFull = ((N_ENTRIES - int'(count)) <= THRESHOLD);

  // Age-ordered view of the buffer starting at the read pointer.
  always_comb begin
    idx = 0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      peek_valid[i] = (i < int'(count));
      idx = int'(rd_ptr) + i;
      if (idx >= N_ENTRIES) idx = idx - N_ENTRIES;
      peek_value[i] = mem[idx[PW-1:0]];
    end
  end

  assign first = peek_value[0];

`ifndef SYNTHESIS
  // Protocol guards: strobes against the wrong flag are caller bugs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enq_en && !notFull)  $fatal(1, "ENQ to full FIFO!");
      if (deq_en && !notEmpty) $fatal(1, "DEQ from empty FIFO!");
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_fifo_regn.sv
// Bench for cci_mpf_prim_fifo_regn: a depth-4 and a depth-3 instance are
// driven with directed sequences and then random traffic, and compared on
// every negative clock edge against queue-based reference models.
module tb_cci_mpf_prim_fifo_regn;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: N_ENTRIES=4, THRESHOLD=1
  logic [31:0]      a_data;
  logic             a_enq, a_deq;
  logic             a_nf, a_af, a_ne;
  logic [31:0]      a_first;
  logic [2:0]       a_count;
  logic [3:0]       a_pvld;
  logic [3:0][31:0] a_pval;

  // Instance B: N_ENTRIES=3, THRESHOLD=1
  logic [31:0]      b_data;
  logic             b_enq, b_deq;
  logic             b_nf, b_af, b_ne;
  logic [31:0]      b_first;
  logic [1:0]       b_count;
  logic [2:0]       b_pvld;
  logic [2:0][31:0] b_pval;

  cci_mpf_prim_fifo_regn #(.N_DATA_BITS(32), .N_ENTRIES(4), .THRESHOLD(1)) dut_a (
    .clk(clk), .reset(reset),
    .enq_data(a_data), .enq_en(a_enq), .notFull(a_nf), .almostFull(a_af),
    .first(a_first), .deq_en(a_deq), .notEmpty(a_ne),
    .count(a_count), .peek_valid(a_pvld), .peek_value(a_pval)
  );

  cci_mpf_prim_fifo_regn #(.N_DATA_BITS(32), .N_ENTRIES(3), .THRESHOLD(1)) dut_b (
    .clk(clk), .reset(reset),
    .enq_data(b_data), .enq_en(b_enq), .notFull(b_nf), .almostFull(b_af),
    .first(b_first), .deq_en(b_deq), .notEmpty(b_ne),
    .count(b_count), .peek_valid(b_pvld), .peek_value(b_pval)
  );

  int passed = 0;
  int total  = 0;
  bit armed  = 1'b0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference models: plain queues updated from the strobes seen at each edge.
  always @(posedge clk) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_deq) void'(qa.pop_front());
      if (a_enq) qa.push_back(a_data);
      if (b_deq) void'(qb.pop_front());
      if (b_enq) qb.push_back(b_data);
    end
  end

  // Cycle-by-cycle comparison of both instances against the models.
  always @(negedge clk) begin
    if (armed) begin
      chk("a_count",    64'(a_count), 64'(qa.size()));
      chk("a_notEmpty", 64'(a_ne),    64'(qa.size() != 0));
      chk("a_notFull",  64'(a_nf),    64'(qa.size() != 4));
      chk("a_almostFull", 64'(a_af),  64'((4 - qa.size()) <= 1));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("a_peek_valid[%0d]", i), 64'(a_pvld[i]), 64'(i < qa.size()));
        if (i < qa.size())
          chk($sformatf("a_peek_value[%0d]", i), 64'(a_pval[i]), 64'(qa[i]));
      end
      if (qa.size() > 0) chk("a_first", 64'(a_first), 64'(qa[0]));

      chk("b_count",    64'(b_count), 64'(qb.size()));
      chk("b_notEmpty", 64'(b_ne),    64'(qb.size() != 0));
      chk("b_notFull",  64'(b_nf),    64'(qb.size() != 3));
      chk("b_almostFull", 64'(b_af),  64'((3 - qb.size()) <= 1));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b_peek_valid[%0d]", i), 64'(b_pvld[i]), 64'(i < qb.size()));
        if (i < qb.size())
          chk($sformatf("b_peek_value[%0d]", i), 64'(b_pval[i]), 64'(qb[i]));
      end
      if (qb.size() > 0) chk("b_first", 64'(b_first), 64'(qb[0]));
    end
  end

  task automatic cyc_a(input logic e, input logic [31:0] d, input logic dq);
    a_enq = e; a_data = d; a_deq = dq;
    @(posedge clk); #1;
    a_enq = 1'b0; a_deq = 1'b0;
  endtask

  task automatic cyc_b(input logic e, input logic [31:0] d, input logic dq);
    b_enq = e; b_data = d; b_deq = dq;
    @(posedge clk); #1;
    b_enq = 1'b0; b_deq = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_enq = 1'b0; a_deq = 1'b0; a_data = '0;
    b_enq = 1'b0; b_deq = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;

    // Post-reset state
    chk("rst_count",      64'(a_count), 64'd0);
    chk("rst_notFull",    64'(a_nf),    64'd1);
    chk("rst_notEmpty",   64'(a_ne),    64'd0);
    chk("rst_almostFull", 64'(a_af),    64'd0);
    chk("rst_peek_valid", 64'(a_pvld),  64'd0);

    // Fill with A0..A3
    for (int k = 0; k < 4; k++) begin
      cyc_a(1'b1, 32'hA0 + 32'(k), 1'b0);
      chk("fill_count", 64'(a_count), 64'(k + 1));
      chk("fill_almostFull", 64'(a_af), 64'(k >= 2));
      chk("fill_notFull", 64'(a_nf), 64'(k != 3));
    end
    for (int i = 0; i < 4; i++)
      chk("fill_peek", 64'(a_pval[i]), 64'(32'hA0 + 32'(i)));

    // Drain in order
    for (int k = 0; k < 4; k++) begin
      chk("drain_first", 64'(a_first), 64'(32'hA0 + 32'(k)));
      cyc_a(1'b0, '0, 1'b1);
    end
    chk("drain_notEmpty", 64'(a_ne), 64'd0);
    chk("drain_count",    64'(a_count), 64'd0);

    // Streaming at count=2 with pointer wrap
    cyc_a(1'b1, 32'd100, 1'b0);
    cyc_a(1'b1, 32'd101, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("stream_first", 64'(a_first), (k < 2) ? 64'(100 + k) : 64'(k - 2));
      cyc_a(1'b1, 32'(k), 1'b1);
      chk("stream_count", 64'(a_count), 64'd2);
    end
    chk("stream_tail0", 64'(a_first), 64'd8);
    cyc_a(1'b0, '0, 1'b1);
    chk("stream_tail1", 64'(a_first), 64'd9);
    cyc_a(1'b0, '0, 1'b1);

    // One-cycle latency into an empty FIFO
    a_enq = 1'b1; a_data = 32'h55;
    #1;
    chk("lat_same_cycle_notEmpty", 64'(a_ne), 64'd0);
    @(posedge clk); #1;
    a_enq = 1'b0;
    chk("lat_next_notEmpty", 64'(a_ne), 64'd1);
    chk("lat_next_first", 64'(a_first), 64'h55);
    cyc_a(1'b0, '0, 1'b1);

    // Reset in the middle of operation, with enq asserted
    cyc_a(1'b1, 32'h11, 1'b0);
    cyc_a(1'b1, 32'h12, 1'b0);
    cyc_a(1'b1, 32'h13, 1'b0);
    chk("mid_pre_count", 64'(a_count), 64'd3);
    reset = 1'b1; a_enq = 1'b1; a_data = 32'h99;
    @(posedge clk); #1;
    reset = 1'b0; a_enq = 1'b0;
    chk("mid_count",    64'(a_count), 64'd0);
    chk("mid_notEmpty", 64'(a_ne),    64'd0);
    chk("mid_notFull",  64'(a_nf),    64'd1);
    cyc_a(1'b1, 32'h77, 1'b0);
    chk("mid_first", 64'(a_first), 64'h77);
    cyc_a(1'b0, '0, 1'b1);

    // Depth-3 instance: 7 enq/deq pairs at count=2
    cyc_b(1'b1, 32'd200, 1'b0);
    cyc_b(1'b1, 32'd201, 1'b0);
    for (int k = 0; k < 7; k++) begin
      chk("n3_first", 64'(b_first), (k < 2) ? 64'(200 + k) : 64'(k - 2));
      cyc_b(1'b1, 32'(k), 1'b1);
    end
    chk("n3_count", 64'(b_count), 64'd2);
    chk("n3_tail0", 64'(b_first), 64'd5);
    cyc_b(1'b0, '0, 1'b1);
    chk("n3_tail1", 64'(b_first), 64'd6);
    cyc_b(1'b0, '0, 1'b1);

    // Random traffic on both instances, with occasional resets
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      a_enq = ($urandom_range(0, 2) != 0) && (qa.size() < 4);
      a_deq = ($urandom_range(0, 1) != 0) && (qa.size() > 0);
      a_data = $urandom;
      b_enq = ($urandom_range(0, 1) != 0) && (qb.size() < 3);
      b_deq = ($urandom_range(0, 2) != 0) && (qb.size() > 0);
      b_data = $urandom;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    a_enq = 1'b0; a_deq = 1'b0;
    b_enq = 1'b0; b_deq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    armed = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
